// File: rtl/sopc_timer_slave_if.sv
// sopc_timer_slave_if: data-RAM style bus (ce/we/addr/sel/data) plus timer interrupt line
interface sopc_timer_slave_if;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        timer_irq_o;
  modport master (output ce, we, addr, sel, data_i, input data_o, timer_irq_o);
  modport slave (input ce, we, addr, sel, data_i, output data_o, timer_irq_o);
endinterface

// File: rtl/sopc_timer_slave.sv
// sopc_timer_slave: memory-mapped 64-bit mtime/mtimecmp machine timer with level IRQ.
// Define SOPC_TIMER_PRESCALE_EN to tick mtime every PRESCALE-th enabled cycle.
module sopc_timer_slave #(
  parameter int unsigned PRESCALE = 4,
  parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input logic clk,
  input logic rst,
  sopc_timer_slave_if.slave bus
);
  logic [63:0] mtime, mtimecmp, mtime_nx, cmp_nx;
  logic en, en_nx, tick, wr, pend;
  logic [2:0] idx;
  logic [31:0] mask;
  assign idx = bus.addr[4:2];
  assign wr = bus.ce & bus.we;
  assign mask = {{8{bus.sel[3]}}, {8{bus.sel[2]}}, {8{bus.sel[1]}}, {8{bus.sel[0]}}};
  assign pend = mtime >= mtimecmp;
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [31:0] m);
    return (old & ~m) | (d & m);
  endfunction
`ifdef SOPC_TIMER_PRESCALE_EN
  localparam int unsigned PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pcnt;
  logic unused_addr;
  assign tick = en & (pcnt == PW'(PRESCALE - 1));
  assign unused_addr = ^{bus.addr[31:5], bus.addr[1:0]};
  always_ff @(posedge clk)
    if (rst) pcnt <= '0;
    else if (en) pcnt <= tick ? '0 : pcnt + 1'b1;
`else
  logic unused_cfg;
  assign tick = en;
  assign unused_cfg = ^{bus.addr[31:5], bus.addr[1:0], PRESCALE == 0};
`endif
  // A store to either mtime half replaces that cycle's increment
  always_comb begin
    en_nx = (wr && idx == 3'd4 && bus.sel[0]) ? bus.data_i[0] : en;
    mtime_nx = mtime;
    cmp_nx = mtimecmp;
    if (wr && idx == 3'd0) mtime_nx[31:0] = merge(mtime[31:0], bus.data_i, mask);
    else if (wr && idx == 3'd1) mtime_nx[63:32] = merge(mtime[63:32], bus.data_i, mask);
    else if (tick) mtime_nx = mtime + 64'd1;
    if (wr && idx == 3'd2) cmp_nx[31:0] = merge(mtimecmp[31:0], bus.data_i, mask);
    if (wr && idx == 3'd3) cmp_nx[63:32] = merge(mtimecmp[63:32], bus.data_i, mask);
  end
  assign bus.data_o = (!bus.ce || bus.we) ? '0 :
                      idx == 3'd0 ? mtime[31:0] :
                      idx == 3'd1 ? mtime[63:32] :
                      idx == 3'd2 ? mtimecmp[31:0] :
                      idx == 3'd3 ? mtimecmp[63:32] :
                      idx == 3'd4 ? {30'd0, pend, en} : '0;
  always_ff @(posedge clk)
    if (rst) begin
      mtime <= '0;
      mtimecmp <= CMP_RST;
      en <= 1'b0;
      bus.timer_irq_o <= 1'b0;
    end else begin
      mtime <= mtime_nx;
      mtimecmp <= cmp_nx;
      en <= en_nx;
      bus.timer_irq_o <= en_nx & (mtime_nx >= cmp_nx);
    end
endmodule

// File: tb/tb_sopc_timer_slave.sv
// tb_sopc_timer_slave: directed + randomized bus traffic checked against a register-level timer model
module tb_sopc_timer_slave;
  localparam int PRESCALE = 4;
`ifdef SOPC_TIMER_PRESCALE_EN
  localparam int TICKDIV = PRESCALE;
`else
  localparam int TICKDIV = 1;
`endif
  logic clk = 0, rst = 1;
  int n_tests = 0, n_fail = 0;
  sopc_timer_slave_if bus();
  sopc_timer_slave #(.PRESCALE(PRESCALE)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #10 clk = ~clk;
  logic [63:0] m_time, m_cmp;
  logic m_en, m_irq, tk, w;
  int m_pre;
  logic [2:0] k;
  function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction
  // Reference: tick every TICKDIV enabled cycles, stores win over ticks, IRQ from post-update state
  always @(posedge clk) begin
    if (rst) begin
      m_time = 0; m_cmp = '1; m_en = 0; m_pre = 0; m_irq = 0;
    end else begin
      tk = 0;
      if (m_en) begin
        if (m_pre == TICKDIV - 1) begin tk = 1; m_pre = 0; end
        else m_pre = m_pre + 1;
      end
      w = bus.ce && bus.we;
      k = bus.addr[4:2];
      if (w && k == 0) m_time[31:0] = lanes(m_time[31:0], bus.data_i, bus.sel);
      else if (w && k == 1) m_time[63:32] = lanes(m_time[63:32], bus.data_i, bus.sel);
      else if (tk) m_time = m_time + 1;
      if (w && k == 2) m_cmp[31:0] = lanes(m_cmp[31:0], bus.data_i, bus.sel);
      if (w && k == 3) m_cmp[63:32] = lanes(m_cmp[63:32], bus.data_i, bus.sel);
      if (w && k == 4 && bus.sel[0]) m_en = bus.data_i[0];
      m_irq = m_en && (m_time >= m_cmp);
    end
  end
  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    case (a[4:2])
      3'd0: return m_time[31:0];
      3'd1: return m_time[63:32];
      3'd2: return m_cmp[31:0];
      3'd3: return m_cmp[63:32];
      3'd4: return {30'd0, m_time >= m_cmp, m_en};
      default: return 32'd0;
    endcase
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    bus.ce = 1; bus.we = 0; bus.addr = a; bus.sel = 4'($urandom);
    #1 check(tag, bus.data_o, exp);
    bus.ce = 0; bus.addr = 0;
  endtask
  task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    bus.ce = 1; bus.we = 1; bus.addr = a; bus.sel = s; bus.data_i = d;
    #1 check("data_o_during_write", bus.data_o, 0);
    @(posedge clk);
    @(negedge clk);
    bus.ce = 0; bus.we = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      check("irq", bus.timer_irq_o, m_irq);
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.ce = 0; bus.we = 0; bus.addr = 0; bus.sel = 0; bus.data_i = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    rd(32'h00, 32'h0, "rst_mtime_lo");
    rd(32'h04, 32'h0, "rst_mtime_hi");
    rd(32'h08, 32'hFFFF_FFFF, "rst_cmp_lo");
    rd(32'h0C, 32'hFFFF_FFFF, "rst_cmp_hi");
    rd(32'h10, 32'h0, "rst_ctrl");
    check("rst_irq", bus.timer_irq_o, 0);
    wr(32'h10, 4'hF, 1);
    idle(10 * TICKDIV);
    rd(32'h00, 32'd10, "count10");
    wr(32'h10, 4'hF, 0);
    wr(32'h00, 4'hF, 32'hFFFF_FFFE);
    wr(32'h04, 4'hF, 32'h0);
    wr(32'h10, 4'hF, 1);
    idle(3 * TICKDIV);
    rd(32'h04, 32'd1, "carry_hi");
    rd(32'h00, 32'd1, "carry_lo");
    wr(32'h10, 4'hF, 0);
    wr(32'h00, 4'b0001, 32'h1234_56AB);
    rd(32'h00, 32'h0000_00AB, "byte_lane");
    rd(32'h04, 32'd1, "byte_lane_hi_held");
    wr(32'h00, 4'hF, 0);
    wr(32'h04, 4'hF, 0);
    wr(32'h0C, 4'hF, 0);
    wr(32'h08, 4'hF, 32'h20);
    wr(32'h10, 4'hF, 1);
    for (int i = 0; i < 64 * TICKDIV && m_time < 64'h22; i++) idle(1);
    check("irq_raised", bus.timer_irq_o, 1);
    rd(32'h10, 32'h3, "pend_set");
    wr(32'h08, 4'hF, 32'h100);
    check("irq_cleared", bus.timer_irq_o, 0);
    rd(32'h10, 32'h1, "pend_clear");
    wr(32'h10, 4'hF, 0);
    wr(32'h00, 4'hF, 32'hFFFF_FFFF);
    wr(32'h04, 4'hF, 32'hFFFF_FFFF);
    wr(32'h10, 4'hF, 1);
    idle(TICKDIV);
    rd(32'h00, 32'h0, "wrap_lo");
    rd(32'h04, 32'h0, "wrap_hi");
    bus.ce = 1; bus.we = 1; bus.addr = 32'h08; bus.sel = 4'hF; bus.data_i = 32'h5;
    rst = 1;
    @(negedge clk);
    rst = 0; bus.ce = 0; bus.we = 0;
    rd(32'h08, 32'hFFFF_FFFF, "rst_over_store_lo");
    rd(32'h0C, 32'hFFFF_FFFF, "rst_over_store_hi");
    check("rst_over_store_irq", bus.timer_irq_o, 0);
    wr(32'h10, 4'hF, 1);
    idle(5);
    wr(32'h14, 4'hF, 32'hDEAD_BEEF);
    for (int a = 0; a <= 16; a += 4) rd(a, exp_rd(a), "unmapped_untouched");
    rd(32'h14, 32'h0, "unmapped_read");
    bus.ce = 0; bus.addr = 0;
    #1 check("ce_low_data", bus.data_o, 0);
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [2:0] ri;
      logic [31:0] d;
      r = $urandom_range(0, 19);
      ri = 3'($urandom_range(0, 7));
      d = (ri == 1 || ri == 3) ? 32'($urandom_range(0, 2)) :
          (ri == 4) ? 32'($urandom_range(0, 1)) : $urandom;
      if (r < 8) wr({27'd0, ri, 2'b00}, 4'($urandom), d);
      else if (r < 18) rd({$urandom_range(0, 7) << 5, ri, 2'($urandom)}, exp_rd({27'd0, ri, 2'b00}), "rand_read");
      else if (r == 19) begin
        rst = 1;
        @(negedge clk);
        rst = 0;
      end
      idle(1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
